// File: rtl/stack_unit.sv
// stack_unit: parametrised LIFO with an internal stack pointer, registered
// pop data, full/empty/count status and sticky overflow/underflow flags.
module stack_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] top,
  output logic [PTR_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH:0] L_DEPTH = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] L_ONE   = (PTR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH:0]    r_sp;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dv;
  logic                  r_ovf;
  logic                  r_udf;

  logic                  w_full;
  logic                  w_empty;
  logic [PTR_WIDTH-1:0]  w_top_idx;
  logic [DATA_WIDTH-1:0] w_top_data;
  logic                  w_op_clr;
  logic                  w_op_swap;
  logic                  w_op_push;
  logic                  w_op_pop;

  logic [PTR_WIDTH:0]    w_sp_nxt;
  logic [DATA_WIDTH-1:0] w_dout_nxt;
  logic                  w_dv_nxt;
  logic                  w_ovf_nxt;
  logic                  w_udf_nxt;
  logic                  w_wr_en;
  logic [PTR_WIDTH-1:0]  w_wr_idx;

  assign w_full     = (r_sp == L_DEPTH);
  assign w_empty    = (r_sp == '0);
  // sp is the next free slot, so the top lives one below it
  assign w_top_idx  = PTR_WIDTH'(r_sp - L_ONE);
  assign w_top_data = r_mem[w_top_idx];

  assign w_op_clr  = clear;
  assign w_op_swap = !clear && push && pop;
  assign w_op_push = !clear && push && !pop;
  assign w_op_pop  = !clear && pop && !push;

  always_comb begin
    w_sp_nxt   = r_sp;
    w_dout_nxt = r_dout;
    w_dv_nxt   = 1'b0;
    w_ovf_nxt  = r_ovf;
    w_udf_nxt  = r_udf;
    w_wr_en    = 1'b0;
    w_wr_idx   = r_sp[PTR_WIDTH-1:0];
    unique case (1'b1)
      w_op_clr: begin
        w_sp_nxt  = '0;
        w_ovf_nxt = 1'b0;
        w_udf_nxt = 1'b0;
      end
      w_op_swap: begin
        w_dv_nxt = 1'b1;
        if (w_empty) begin
          w_dout_nxt = data_in;
        end else begin
          w_dout_nxt = w_top_data;
          w_wr_en    = 1'b1;
          w_wr_idx   = w_top_idx;
        end
      end
      w_op_push: begin
        if (w_full) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_wr_en  = 1'b1;
          w_sp_nxt = r_sp + L_ONE;
        end
      end
      w_op_pop: begin
        if (w_empty) begin
          w_udf_nxt = 1'b1;
        end else begin
          w_dout_nxt = w_top_data;
          w_dv_nxt   = 1'b1;
          w_sp_nxt   = r_sp - L_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sp   <= '0;
      r_dout <= '0;
      r_dv   <= 1'b0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      r_sp   <= w_sp_nxt;
      r_dout <= w_dout_nxt;
      r_dv   <= w_dv_nxt;
      r_ovf  <= w_ovf_nxt;
      r_udf  <= w_udf_nxt;
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= data_in;
  end

  assign data_out   = r_dout;
  assign data_valid = r_dv;
  assign top        = w_empty ? '0 : w_top_data;
  assign count      = r_sp;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_ovf;
  assign underflow  = r_udf;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: vector table, corner sequences and a randomized run
// against a queue-based LIFO model.
module tb_stack_unit;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clear, push, pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out, top;
  logic          data_valid, full, empty, overflow, underflow;
  logic [PW:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  stack_unit #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid),
    .top(top), .count(count), .full(full),
    .empty(empty), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          psh;
    logic          pp;
    logic [DW-1:0] din;
    logic [DW-1:0] e_dout;
    logic          e_dv;
    int            e_cnt;
    logic [DW-1:0] e_top;
    logic          e_ovf;
    logic          e_udf;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [DW-1:0] e_dout,
                         input logic e_dv, input int e_cnt,
                         input logic [DW-1:0] e_top,
                         input logic e_ovf, input logic e_udf);
    chk({tag, ".data_out"}, data_out, e_dout);
    chk({tag, ".data_valid"}, DW'(data_valid), DW'(e_dv));
    chk({tag, ".count"}, DW'(count), DW'(e_cnt));
    chk({tag, ".top"}, top, e_top);
    chk({tag, ".full"}, DW'(full), DW'(e_cnt == DP));
    chk({tag, ".empty"}, DW'(empty), DW'(e_cnt == 0));
    chk({tag, ".overflow"}, DW'(overflow), DW'(e_ovf));
    chk({tag, ".underflow"}, DW'(underflow), DW'(e_udf));
  endtask

  task automatic drive(input logic c, input logic pu,
                       input logic po, input logic [DW-1:0] d);
    clear = c; push = pu; pop = po; data_in = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic c, input logic pu,
                              input logic po,
                              input logic [DW-1:0] d,
                              input logic [DW-1:0] edo,
                              input logic edv, input int ec,
                              input logic [DW-1:0] et,
                              input logic eo, input logic eu);
    vec_t v;
    v.clr = c; v.psh = pu; v.pp = po; v.din = d;
    v.e_dout = edo; v.e_dv = edv; v.e_cnt = ec;
    v.e_top = et; v.e_ovf = eo; v.e_udf = eu;
    return v;
  endfunction

  // reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_dv, m_ovf, m_udf;

  task automatic model_step(input logic c, input logic pu,
                            input logic po,
                            input logic [DW-1:0] d);
    m_dv = 1'b0;
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (pu && po) begin
      m_dv = 1'b1;
      if (q.size() == 0) begin
        m_dout = d;
      end else begin
        m_dout = q.pop_back();
        q.push_back(d);
      end
    end else if (pu) begin
      if (q.size() < DP) q.push_back(d);
      else m_ovf = 1'b1;
    end else if (po) begin
      if (q.size() > 0) begin
        m_dout = q.pop_back();
        m_dv   = 1'b1;
      end else begin
        m_udf = 1'b1;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", '0, 0, 0, '0, 0, 0);
    reset_n = 1'b1;

    vecs[0]  = mk(0,0,0,0,          0,0,0,0,0,0);
    vecs[1]  = mk(0,1,0,32'hDEADBEEF, 0,0,1,32'hDEADBEEF,0,0);
    vecs[2]  = mk(0,1,0,32'h12345678, 0,0,2,32'h12345678,0,0);
    vecs[3]  = mk(0,0,1,0, 32'h12345678,1,1,32'hDEADBEEF,0,0);
    vecs[4]  = mk(0,0,1,0, 32'hDEADBEEF,1,0,0,0,0);
    vecs[5]  = mk(0,0,0,0, 32'hDEADBEEF,0,0,0,0,0);
    vecs[6]  = mk(0,0,1,0, 32'hDEADBEEF,0,0,0,0,1);
    vecs[7]  = mk(0,1,0,32'hA5, 32'hDEADBEEF,0,1,32'hA5,0,1);
    vecs[8]  = mk(1,0,0,0, 32'hDEADBEEF,0,0,0,0,0);
    vecs[9]  = mk(0,1,0,1, 32'hDEADBEEF,0,1,1,0,0);
    vecs[10] = mk(0,1,0,2, 32'hDEADBEEF,0,2,2,0,0);
    vecs[11] = mk(0,1,1,9, 2,1,2,9,0,0);
    vecs[12] = mk(0,0,1,0, 9,1,1,1,0,0);
    vecs[13] = mk(0,0,1,0, 1,1,0,0,0,0);
    vecs[14] = mk(0,1,1,7, 7,1,0,0,0,0);
    vecs[15] = mk(1,1,1,3, 7,0,0,0,0,0);
    vecs[16] = mk(1,1,0,4, 7,0,0,0,0,0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].clr, vecs[i].psh, vecs[i].pp, vecs[i].din);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_dout,
              vecs[i].e_dv, vecs[i].e_cnt, vecs[i].e_top,
              vecs[i].e_ovf, vecs[i].e_udf);
    end

    // fill to full, overflow, replace-top while full
    for (int i = 0; i < DP; i++) begin
      drive(0, 1, 0, DW'(i));
      step();
      chk_all($sformatf("fill%0d", i), 7, 0, i + 1, DW'(i), 0, 0);
    end
    drive(0, 1, 0, 32'hFF);
    step();
    chk_all("ovf", 7, 0, DP, 15, 1, 0);
    drive(0, 1, 1, 32'hAB);
    step();
    chk_all("swapfull", 15, 1, DP, 32'hAB, 1, 0);
    drive(0, 0, 1, 0);
    step();
    chk_all("popfull", 32'hAB, 1, DP - 1, 14, 1, 0);
    drive(0, 0, 1, 0);
    step();
    chk_all("pop14", 14, 1, DP - 2, 13, 1, 0);
    drive(1, 0, 0, 0);
    step();
    chk_all("clr", 14, 0, 0, 0, 0, 0);

    // randomized run against the LIFO model
    q.delete();
    m_dout = 14; m_dv = 0; m_ovf = 0; m_udf = 0;
    for (int i = 0; i < 900; i++) begin
      logic c, pu, po;
      logic [DW-1:0] d;
      int ph;
      ph = (i / 100) % 3;
      c  = ($urandom_range(99) < 2);
      pu = ($urandom_range(99) < (ph == 0 ? 80 : ph == 1 ? 25 : 50));
      po = ($urandom_range(99) < (ph == 1 ? 80 : ph == 0 ? 25 : 50));
      d  = $urandom;
      drive(c, pu, po, d);
      model_step(c, pu, po, d);
      step();
      chk_all($sformatf("rnd%0d", i), m_dout, m_dv, q.size(),
              q.size() > 0 ? q[$] : '0, m_ovf, m_udf);
    end

    // async reset during an in-flight pop
    drive(1, 0, 0, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, DW'(100 + i));
      step();
    end
    drive(0, 0, 1, 0);
    step();
    chk_all("prerst", 105, 1, 5, 104, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("asyncrst", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk_all("postrst0", 0, 0, 0, 0, 0, 0);
    step();
    chk_all("postrst1", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
Parametrised hardware LIFO for the multi-cycle RISC processor's CALL/RET and PUSH/POP datapath. It supersedes the externally addressed stack memory, which took a stack pointer from outside.
- Owns its stack pointer internally.
- Registers popped data.
- Reports full/empty/count.
- Flags overflow/underflow as sticky errors for the control unit.
- Supports same-cycle push+pop (replace-top).

Parameters:
DATA_WIDTH, 32, width of each stack entry
DEPTH, 16, number of entries (power of two, >=2)
PTR_WIDTH, $clog2(DEPTH), width of internal stack pointer; count port is PTR_WIDTH+1 bits

Ports:
clk  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush; empties stack and clears error flags
push  input  1  write data_in as new top this cycle
pop  input  1  remove current top this cycle; value appears on data_out next cycle
data_in  input  DATA_WIDTH  push data
data_out  output  DATA_WIDTH  registered popped value
data_valid  output  1  one-cycle pulse: data_out updated by the previous cycle's pop
top  output  DATA_WIDTH  combinational peek of current top entry (0 when empty)
count  output  PTR_WIDTH+1  number of valid entries, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky: push attempted while full without pop
underflow  output  1  sticky: pop attempted while empty without push

Behaviour:
- Reset (reset_n low, asynchronous):
  - sp=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0; hence empty=1, full=0, top=0.
  - Storage array is not reset.
- All state updates on the rising clk edge. full, empty, count and top derive from registered sp.
- sp points to the next free slot; the top entry is mem[sp-1].
- Priority per cycle: clear > push/pop decode.
- clear=1:
  - sp=0; overflow and underflow cleared; data_valid=0; data_out holds.
  - push/pop ignored that cycle.
- push only, not full: mem[sp]=data_in, sp+1. data_valid=0.
- push only, full: no write, sp unchanged, overflow set. data_valid=0.
- pop only, not empty: data_out<=mem[sp-1], sp-1, data_valid=1 next cycle (1-cycle latency).
- pop only, empty: sp unchanged, data_out holds, data_valid=0, underflow set.
- push+pop, not empty (including full):
  - data_out<=old top, data_valid=1.
  - mem[sp-1]<=data_in; sp and count unchanged; no flag set.
- push+pop, empty (bypass): data_out<=data_in, data_valid=1, sp stays 0, no flag set.
- data_valid is a single-cycle pulse. Back-to-back pops give consecutive pulses with successive entries (LIFO order).
- Sticky flags stay set until clear or reset; they never block further legal operations.
- sp never wraps: 0..DEPTH inclusive, held by the full/empty guards.
- Reset asserted mid-operation aborts any in-flight pop; data_valid drops immediately.

Test Plan:
1. Reset then idle -> empty=1, full=0, count=0, top=0, data_out=0, data_valid=0, overflow=underflow=0.
2. Push 32'hDEADBEEF, 32'h12345678, then pop twice -> top=12345678 after 2nd push. data_out=12345678 with data_valid pulse, then DEADBEEF with pulse on the following cycle. count returns 0, empty=1.
3. Push 16 values 0..15 (DEPTH=16) -> full=1, count=16. 17th push of 32'hFF -> overflow=1, count=16, top=15. Then pop -> data_out=15, full=0.
4. Pop on empty -> underflow=1, data_valid=0, data_out unchanged. Then push 32'hA5 succeeds (count=1, top=A5). clear -> count=0, underflow=0, overflow=0.
5. Simultaneous push+pop:
   - stack holds [1,2], push 9 with pop -> data_out=2, data_valid=1, count=2, top=9;
   - on empty, push 7 with pop -> data_out=7, count=0, no flags.
6. Assert reset_n low asynchronously between edges while count=5 and pop is pending -> outputs return to reset values immediately, with no data_valid pulse after release.
